// File: rtl/comar_rand_gen.sv
// -----------------------------------------------------------------------------
// comar_rand_gen
//
// Fresh-randomness source for the 2-share COMAR gadget array. Each advancing
// cycle it delivers a 7-bit word. The word is built by running a 31-bit
// Fibonacci LFSR (x^31 + x^28 + 1) forward 7 steps in a single clock. The
// feedback bit of step i drives r[i] for i = 0..5. The feedback bit of step 6
// drives common_out. r and common_out fan out to every gadget instance.
//
// Parameters
//   WARMUP_CYCLES  advancing cycles discarded after a seed is taken (0 allowed)
//   HEALTH_LIMIT   number of consecutive identical valid words that trips the
//                  health alarm (only meaningful with COMAR_RAND_HEALTH_EN)
//
// Ports
//   clk          in   1   single clock, rising edge
//   rst_n        in   1   asynchronous reset, active low
//   seed         in   31  LFSR seed (zero is replaced by 31'h1)
//   seed_valid   in   1   seed offered
//   seed_ready   out  1   seed taken when seed_valid & seed_ready at a rising edge
//   rand_en      in   1   consumer requests a new word (honoured in RUN only)
//   r            out  6   fresh mask bits, registered
//   common_out   out  1   shared output share, registered
//   rand_valid   out  1   r/common_out hold a valid post-warm-up word
//   health_err   out  1   sticky health alarm
//
// Optional feature
//   Define COMAR_RAND_HEALTH_EN to add the repeated-word health monitor.
//   Without it, health_err is tied to 0 and HEALTH_LIMIT has no effect.
// -----------------------------------------------------------------------------
module comar_rand_gen #(
  parameter int WARMUP_CYCLES = 64,
  parameter int HEALTH_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [30:0] seed,
  input  logic        seed_valid,
  output logic        seed_ready,
  input  logic        rand_en,
  output logic [5:0]  r,
  output logic        common_out,
  output logic        rand_valid,
  output logic        health_err
);

  // The counter must reach WARMUP_CYCLES, so it needs clog2(W+1) bits.
  // It is kept at least 1 bit wide so the declaration stays legal when W is 0.
  localparam int CNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  // A zero warm-up length sends an accepted seed straight to RUN.
  localparam logic [1:0] ST_SEEDED = (WARMUP_CYCLES == 0) ? ST_RUN : ST_WARMUP;

  // Catch nonsensical parameter values when the design is elaborated.
  if (WARMUP_CYCLES < 0 || HEALTH_LIMIT < 1) begin : g_param_check
    $error("comar_rand_gen: need WARMUP_CYCLES >= 0 and HEALTH_LIMIT >= 1");
  end

  logic [1:0]       state;
  logic [30:0]      lfsr;
  logic [CNT_W-1:0] cnt;

  logic [30:0]      lfsr_walk;
  logic [30:0]      lfsr_next;
  logic [6:0]       word_next;
  logic [30:0]      seed_eff;
  logic             seed_fire;
  logic             health_trip;

  assign seed_ready = (state != ST_WARMUP);
  assign seed_fire  = seed_valid & seed_ready;
  // The all-zero state would lock the LFSR up, so it is replaced by 31'h1.
  assign seed_eff   = (seed == 31'h0) ? 31'h1 : seed;

  // This block unrolls seven LFSR steps. It produces the next register value
  // and the 7 feedback bits that form the next output word.
  always_comb begin
    lfsr_walk = lfsr;
    word_next = '0;
    for (int i = 0; i < 7; i++) begin
      word_next[i] = lfsr_walk[30] ^ lfsr_walk[27];
      lfsr_walk    = {lfsr_walk[29:0], lfsr_walk[30] ^ lfsr_walk[27]};
    end
    lfsr_next = lfsr_walk;
  end

`ifdef COMAR_RAND_HEALTH_EN
  localparam int RUN_W = $clog2(HEALTH_LIMIT + 1);

  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_cnt_next;
  logic             repeat_word;

  // A new word that equals the previous valid word extends the run.
  // Any other word restarts the run at 1. The alarm trips as soon as the
  // run reaches HEALTH_LIMIT. The run therefore never grows past the limit,
  // and RUN_W bits are enough to hold it.
  always_comb begin
    repeat_word  = rand_valid && (word_next == {common_out, r});
    run_cnt_next = repeat_word ? run_cnt + 1'b1 : RUN_W'(1);
    health_trip  = (run_cnt_next >= RUN_W'(HEALTH_LIMIT));
  end

  // The run counter and the sticky alarm are cleared only by reset or by a
  // newly accepted seed. They update only on cycles that produce a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt    <= '0;
      health_err <= 1'b0;
    end else if (seed_fire) begin
      run_cnt    <= '0;
      health_err <= 1'b0;
    end else if (state == ST_RUN && rand_en) begin
      run_cnt <= run_cnt_next;
      if (health_trip) begin
        health_err <= 1'b1;
      end
    end
  end
`else
  assign health_trip = 1'b0;
  assign health_err  = 1'b0;
`endif

  // This is the main sequencer.
  // IDLE waits for a seed.
  // WARMUP advances every cycle and discards the words it produces.
  // RUN advances only on request, and a new seed may interrupt it at any time.
  // A seed always takes priority over rand_en, and no word is produced on
  // the edge that accepts a seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lfsr       <= 31'h1;
      cnt        <= '0;
      r          <= '0;
      common_out <= 1'b0;
      rand_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (seed_fire) begin
            lfsr  <= seed_eff;
            cnt   <= '0;
            state <= ST_SEEDED;
          end
        end
        ST_WARMUP: begin
          lfsr       <= lfsr_next;
          r          <= word_next[5:0];
          common_out <= word_next[6];
          rand_valid <= 1'b0;
          cnt        <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (seed_fire) begin
            lfsr       <= seed_eff;
            cnt        <= '0;
            rand_valid <= 1'b0;
            state      <= ST_SEEDED;
          end else if (rand_en) begin
            lfsr       <= lfsr_next;
            r          <= word_next[5:0];
            common_out <= word_next[6];
            if (health_trip) begin
              rand_valid <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              rand_valid <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comar_rand_gen.sv
// -----------------------------------------------------------------------------
// tb_comar_rand_gen
//
// Self-checking bench for comar_rand_gen. It drives three instances:
//   dut_z  WARMUP_CYCLES = 0
//   dut_f  WARMUP_CYCLES = 4
//   dut_d  default WARMUP_CYCLES (64)
// All instances share one clock and one reset.
//
// Expected words come from a bit-stream model of the LFSR sequence. The seed
// bits, oldest first, start the stream a[]. Every later bit obeys
//   a[n] = a[n-31] ^ a[n-28]
// Bit i of stream word w is a[31 + 7*w + i], and bit 6 of that word is
// common_out.
// -----------------------------------------------------------------------------
module tb_comar_rand_gen;

  logic clk = 1'b0;
  logic rst_n;

  logic [30:0] seed_z, seed_f, seed_d;
  logic        seed_valid_z, seed_valid_f, seed_valid_d;
  logic        seed_ready_z, seed_ready_f, seed_ready_d;
  logic        rand_en_z, rand_en_f, rand_en_d;
  logic [5:0]  r_z, r_f, r_d;
  logic        common_out_z, common_out_f, common_out_d;
  logic        rand_valid_z, rand_valid_f, rand_valid_d;
  logic        health_err_z, health_err_f, health_err_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comar_rand_gen #(.WARMUP_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .seed(seed_z), .seed_valid(seed_valid_z),
    .seed_ready(seed_ready_z), .rand_en(rand_en_z), .r(r_z),
    .common_out(common_out_z), .rand_valid(rand_valid_z),
    .health_err(health_err_z)
  );

  comar_rand_gen #(.WARMUP_CYCLES(4)) dut_f (
    .clk(clk), .rst_n(rst_n), .seed(seed_f), .seed_valid(seed_valid_f),
    .seed_ready(seed_ready_f), .rand_en(rand_en_f), .r(r_f),
    .common_out(common_out_f), .rand_valid(rand_valid_f),
    .health_err(health_err_f)
  );

  comar_rand_gen dut_d (
    .clk(clk), .rst_n(rst_n), .seed(seed_d), .seed_valid(seed_valid_d),
    .seed_ready(seed_ready_d), .rand_en(rand_en_d), .r(r_d),
    .common_out(common_out_d), .rand_valid(rand_valid_d),
    .health_err(health_err_d)
  );

  // Reference word w of the stream that the given seed produces.
  function automatic logic [6:0] modelWord(input logic [30:0] seed_in, input int idx);
    bit          a [0:1023];
    logic [30:0] s;
    logic [6:0]  w;
    int          last;
    s = (seed_in == 31'h0) ? 31'h1 : seed_in;
    for (int k = 0; k < 31; k++) a[k] = s[30-k];
    last = 31 + 7 * idx + 6;
    for (int n = 31; n <= last; n++) a[n] = a[n-31] ^ a[n-28];
    for (int i = 0; i < 7; i++) w[i] = a[31 + 7 * idx + i];
    return w;
  endfunction

  // One comparison: counts it, and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sets the inputs of one instance: 0 = dut_z, 1 = dut_f, 2 = dut_d.
  task automatic applyStimulus(input int unit, input logic sv, input logic [30:0] sd,
                               input logic en);
    case (unit)
      0: begin seed_valid_z = sv; seed_z = sd; rand_en_z = en; end
      1: begin seed_valid_f = sv; seed_f = sd; rand_en_f = en; end
      default: begin seed_valid_d = sv; seed_d = sd; rand_en_d = en; end
    endcase
  endtask

  // Moves to just after the next rising edge, where outputs are sampled.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [30:0] seed_r, seed_ff, seed_g, seed_h, seed_dd;
    logic [6:0]  exp_word;
    logic        exp_valid;
    logic        en;
    int          idx;
    int          n;

    rst_n = 1'b0;
    applyStimulus(0, 1'b0, 31'h0, 1'b0);
    applyStimulus(1, 1'b0, 31'h0, 1'b0);
    applyStimulus(2, 1'b0, 31'h0, 1'b0);
    #3;
    $display("[TB] reset state");
    checkOutput("reset_out_z", 32'({common_out_z, r_z, rand_valid_z}), 32'h0);
    checkOutput("reset_out_f", 32'({common_out_f, r_f, rand_valid_f}), 32'h0);
    checkOutput("reset_ready_d", 32'(seed_ready_d), 32'h1);
    checkOutput("reset_health_d", 32'(health_err_d), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // In IDLE, rand_en alone must not advance the generator.
    applyStimulus(0, 1'b0, 31'h0, 1'b1);
    tick;
    tick;
    checkOutput("idle_hold_z", 32'({common_out_z, r_z, rand_valid_z}), 32'h0);
    checkOutput("idle_ready_z", 32'(seed_ready_z), 32'h1);

    // With zero warm-up, seed 1 yields three all-zero words, then common_out=1.
    $display("[TB] zero warm-up, seed 1");
    applyStimulus(0, 1'b1, 31'h1, 1'b1);
    tick;
    checkOutput("w0_after_seed_valid", 32'(rand_valid_z), 32'h0);
    checkOutput("w0_after_seed_ready", 32'(seed_ready_z), 32'h1);
    applyStimulus(0, 1'b0, 31'h0, 1'b1);
    for (int w = 0; w < 4; w++) begin
      tick;
      checkOutput("w0_seed1_word", 32'({common_out_z, r_z}), 32'(modelWord(31'h1, w)));
      checkOutput("w0_seed1_valid", 32'(rand_valid_z), 32'h1);
    end
    checkOutput("w0_seed1_word3_const", 32'({common_out_z, r_z}), 32'h40);

    // A seed offered in RUN together with rand_en wins, so no word is produced.
    // After that, random rand_en gaps must neither skip nor repeat words.
    $display("[TB] zero warm-up, random seed and rand_en");
    seed_r = 31'($urandom);
    applyStimulus(0, 1'b1, seed_r, 1'b1);
    tick;
    checkOutput("w0_reseed_valid", 32'(rand_valid_z), 32'h0);
    checkOutput("w0_reseed_hold", 32'({common_out_z, r_z}), 32'h40);
    exp_word  = 7'h40;
    exp_valid = 1'b0;
    idx       = 0;
    for (int c = 0; c < 24; c++) begin
      en = 1'($urandom_range(0, 1));
      applyStimulus(0, 1'b0, 31'h0, en);
      tick;
      if (en) begin
        exp_word  = modelWord(seed_r, idx);
        exp_valid = 1'b1;
        idx++;
      end
      checkOutput("w0_rand_word", 32'({common_out_z, r_z}), 32'(exp_word));
      checkOutput("w0_rand_valid", 32'(rand_valid_z), 32'(exp_valid));
    end

    // Seed 0 is replaced by seed 1, so both must give the same stream.
    $display("[TB] zero seed substitution");
    applyStimulus(0, 1'b1, 31'h0, 1'b1);
    tick;
    applyStimulus(0, 1'b0, 31'h0, 1'b1);
    for (int w = 0; w < 64; w++) begin
      tick;
      checkOutput("zero_seed_word", 32'({common_out_z, r_z}), 32'(modelWord(31'h1, w)));
    end

    // Warm-up of 4 cycles, a rand_en pause, a reseed, and an ignored seed.
    $display("[TB] four-cycle warm-up");
    seed_ff = 31'($urandom);
    applyStimulus(1, 1'b1, seed_ff, 1'b1);
    tick;
    checkOutput("w4_ready_e0", 32'(seed_ready_f), 32'h0);
    checkOutput("w4_valid_e0", 32'(rand_valid_f), 32'h0);
    applyStimulus(1, 1'b0, 31'h0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick;
      checkOutput("w4_warm_word", 32'({common_out_f, r_f}), 32'(modelWord(seed_ff, k - 1)));
      checkOutput("w4_warm_valid", 32'(rand_valid_f), 32'h0);
      checkOutput("w4_warm_ready", 32'(seed_ready_f), 32'(k == 4));
    end
    tick;
    checkOutput("w4_first_valid", 32'(rand_valid_f), 32'h1);
    checkOutput("w4_first_word", 32'({common_out_f, r_f}), 32'(modelWord(seed_ff, 4)));
    applyStimulus(1, 1'b0, 31'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick;
      checkOutput("w4_freeze_word", 32'({common_out_f, r_f}), 32'(modelWord(seed_ff, 4)));
      checkOutput("w4_freeze_valid", 32'(rand_valid_f), 32'h1);
    end
    applyStimulus(1, 1'b0, 31'h0, 1'b1);
    tick;
    checkOutput("w4_resume_word", 32'({common_out_f, r_f}), 32'(modelWord(seed_ff, 5)));

    seed_g = 31'($urandom);
    seed_h = ~seed_g;
    applyStimulus(1, 1'b1, seed_g, 1'b1);
    tick;
    checkOutput("w4_clash_valid", 32'(rand_valid_f), 32'h0);
    checkOutput("w4_clash_hold", 32'({common_out_f, r_f}), 32'(modelWord(seed_ff, 5)));
    checkOutput("w4_clash_ready", 32'(seed_ready_f), 32'h0);
    // seed_h is offered during warm-up and must be ignored.
    applyStimulus(1, 1'b1, seed_h, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick;
      checkOutput("w4_reseed_warm", 32'({common_out_f, r_f}), 32'(modelWord(seed_g, k - 1)));
      if (k == 3) applyStimulus(1, 1'b0, 31'h0, 1'b1);
    end
    tick;
    checkOutput("w4_reseed_word", 32'({common_out_f, r_f}), 32'(modelWord(seed_g, 4)));
    checkOutput("w4_reseed_valid", 32'(rand_valid_f), 32'h1);

    // The default 64-cycle warm-up gives its first valid word 65 edges after
    // the seed edge, and that word is stream word 64.
    $display("[TB] default warm-up");
    seed_dd = 31'($urandom);
    applyStimulus(2, 1'b1, seed_dd, 1'b1);
    tick;
    applyStimulus(2, 1'b0, 31'h0, 1'b1);
    n = 0;
    while (rand_valid_d !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    checkOutput("w64_latency", 32'(n), 32'd65);
    checkOutput("w64_first_word", 32'({common_out_d, r_d}), 32'(modelWord(seed_dd, 64)));
    tick;
    checkOutput("w64_second_word", 32'({common_out_d, r_d}), 32'(modelWord(seed_dd, 65)));
    checkOutput("w64_health", 32'(health_err_d), 32'h0);

    // Reset asserted mid-RUN must clear the outputs before the next edge.
    $display("[TB] asynchronous reset mid-run");
    rst_n = 1'b0;
    #2;
    checkOutput("async_out_d", 32'({common_out_d, r_d, rand_valid_d}), 32'h0);
    checkOutput("async_ready_d", 32'(seed_ready_d), 32'h1);
    checkOutput("async_out_f", 32'({common_out_f, r_f, rand_valid_f}), 32'h0);
    checkOutput("async_out_z", 32'({common_out_z, r_z, rand_valid_z}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
